// File: rtl/phase_pkg.sv
// Shared types for the five-phase instruction sequencer: phase vector, FSM state
// encoding and the ring-successor helper used by the optional phase checker.
package phase_pkg;

    localparam int NUM_PHASES = 5;

    typedef logic [NUM_PHASES-1:0] phase_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTING = 2'd2,
        HALTED  = 2'd3
    } seq_state_t;

    // Rotate one position along the ring p1 -> p2 -> ... -> p5 -> p1.
    function automatic phase_vec_t ring_next(input phase_vec_t v);
        return {v[NUM_PHASES-2:0], v[NUM_PHASES-1]};
    endfunction

    function automatic logic is_onehot(input phase_vec_t v);
        return (v != '0) && ((v & (v - phase_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/phase_checker.sv
// Phase-ring violation detector: flags a sampled phase vector that is not one-hot
// or does not follow the previous sample around the ring.
module phase_checker
    import phase_pkg::*;
(
    input  phase_vec_t sp_i,
    input  phase_vec_t sp_prev_i,
    input  logic       chk_valid_i,
    output logic       violation_o
);

    logic sp_ok_s;
    logic prev_ok_s;
    logic succ_ok_s;

    // A malformed previous sample has no successor, so it also counts as a break.
    always_comb begin
        sp_ok_s     = is_onehot(sp_i);
        prev_ok_s   = is_onehot(sp_prev_i);
        succ_ok_s   = (sp_i == ring_next(sp_prev_i));
        violation_o = chk_valid_i && !(sp_ok_s && prev_ok_s && succ_ok_s);
    end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase stage-enable sequencer with halt/resume control and retire counter.
// Optional ring checking is built when the macro PHASE_CHECK_EN is defined.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             p1,
    input  logic             p2,
    input  logic             p3,
    input  logic             p4,
    input  logic             p5,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             phase_err
);

    phase_vec_t       sp_q;
    phase_vec_t       en_q;
    phase_vec_t       en_d;
    phase_vec_t       en_n_s;
    seq_state_t       state_q;
    seq_state_t       state_d;
    seq_state_t       state_n_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             blocked_s;

`ifdef PHASE_CHECK_EN
    phase_vec_t sp_prev_q;
    logic [1:0] hist_q;
    logic [1:0] hist_d;
    logic       err_q;
    logic       viol_s;
    logic       chk_valid_s;

    // hist counts real samples in sp/sp_prev; a HALTED cycle leaves only sp trustworthy.
    always_comb begin
        if (state_q == HALTED) begin
            hist_d = 2'd1;
        end else if (hist_q == 2'd2) begin
            hist_d = 2'd2;
        end else begin
            hist_d = hist_q + 2'd1;
        end
        chk_valid_s = (hist_q == 2'd2) && (state_q != HALTED);
    end

    phase_checker u_checker (
        .sp_i        (sp_q),
        .sp_prev_i   (sp_prev_q),
        .chk_valid_i (chk_valid_s),
        .violation_o (viol_s)
    );

    // Checker history and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_prev_q <= '0;
            hist_q    <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            sp_prev_q <= sp_q;
            hist_q    <= hist_d;
            err_q     <= err_q | viol_s;
        end
    end

    assign blocked_s = err_q | viol_s;
    assign phase_err = err_q;
`else
    assign blocked_s = 1'b0;
    assign phase_err = 1'b0;
`endif

    // Next-state and enable selection; IDLE issues en_if on the edge it syncs to p1.
    always_comb begin
        state_n_s = state_q;
        en_n_s    = '0;
        case (state_q)
            IDLE: begin
                if (sp_q == phase_vec_t'(5'b00001)) begin
                    state_n_s = RUN;
                    en_n_s    = sp_q;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                en_n_s = sp_q;
                if (halt_req) begin
                    state_n_s = sp_q[4] ? HALTED : HALTING;
                end else begin
                    state_n_s = RUN;
                end
            end
            HALTING: begin
                en_n_s = sp_q;
                if (sp_q[4]) begin
                    state_n_s = HALTED;
                end else begin
                    state_n_s = HALTING;
                end
            end
            HALTED: begin
                if (resume_req) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = HALTED;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase

        if (blocked_s) begin
            state_d = IDLE;
            en_d    = '0;
        end else begin
            state_d = state_n_s;
            en_d    = en_n_s;
        end

        if (en_d[4]) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Phase sampling, FSM state, enables and retire counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q    <= '0;
            state_q <= IDLE;
            en_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sp_q    <= {p5, p4, p3, p2, p1};
            state_q <= state_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en_if      = en_q[0];
    assign en_id      = en_q[1];
    assign en_ex      = en_q[2];
    assign en_mem     = en_q[3];
    assign en_wb      = en_q[4];
    assign halted     = (state_q == HALTED);
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus pushes expected outputs from an
// instruction-level model, a monitor pops and compares one entry per clock.
module tb_phase_sequencer;

    localparam int CW = 4;

    typedef struct packed {
        logic [4:0]    en;
        logic          hlt;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, p4 = 1'b0, p5 = 1'b0;
    logic          halt_req = 1'b0;
    logic          resume_req = 1'b0;
    logic          en_if, en_id, en_ex, en_mem, en_wb;
    logic          halted;
    logic [CW-1:0] retire_cnt;
    logic          phase_err;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Instruction-level model state.
    logic [4:0] sp_m = 5'd0;
    logic [4:0] prev_m = 5'd0;
    int         samples_m = 0;
    bit         issuing = 1'b0;
    bit         stop_pending = 1'b0;
    bit         m_halted = 1'b0;
    bit         m_err = 1'b0;
    int         retired = 0;
    int         ph = 0;

    phase_sequencer #(.CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .halt_req   (halt_req),
        .resume_req (resume_req),
        .en_if      (en_if),
        .en_id      (en_id),
        .en_ex      (en_ex),
        .en_mem     (en_mem),
        .en_wb      (en_wb),
        .halted     (halted),
        .retire_cnt (retire_cnt),
        .phase_err  (phase_err)
    );

    always #5 clock = ~clock;

    function automatic int phase_num(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v == (5'd1 << i)) return i + 1;
        end
        return 0;
    endfunction

    // Drive one cycle of inputs and predict the outputs seen after the next edge.
    task automatic step(input logic r, input logic [4:0] p, input logic h, input logic rs);
        exp_t e;
        bit   was;
        bit   viol;
        @(negedge clock);
        reset = r;
        {p5, p4, p3, p2, p1} = p;
        halt_req = h;
        resume_req = rs;
        e.en = 5'd0;
        if (r) begin
            issuing = 1'b0; stop_pending = 1'b0; m_halted = 1'b0; m_err = 1'b0;
            retired = 0; sp_m = 5'd0; prev_m = 5'd0; samples_m = 0;
        end else begin
            viol = 1'b0;
`ifdef PHASE_CHECK_EN
            if (samples_m >= 2 && !m_halted)
                viol = ($countones(sp_m) != 1) || ($countones(prev_m) != 1) ||
                       (phase_num(sp_m) != (phase_num(prev_m) % 5) + 1);
`endif
            samples_m = m_halted ? 1 : ((samples_m >= 2) ? 2 : samples_m + 1);
            if (viol) m_err = 1'b1;
            if (m_err) begin
                issuing = 1'b0; stop_pending = 1'b0; m_halted = 1'b0;
            end else if (m_halted) begin
                if (rs) m_halted = 1'b0;
            end else begin
                was = issuing;
                if (!issuing && sp_m == 5'b00001) issuing = 1'b1;
                if (issuing) begin
                    e.en = sp_m;
                    if (sp_m[4]) retired = (retired + 1) % (1 << CW);
                    if (was && (stop_pending || h)) begin
                        if (sp_m[4]) begin
                            m_halted = 1'b1; issuing = 1'b0; stop_pending = 1'b0;
                        end else begin
                            stop_pending = 1'b1;
                        end
                    end
                end
            end
            prev_m = sp_m;
            sp_m   = p;
        end
        e.hlt = m_halted;
        e.err = m_err;
        e.cnt = CW'(retired);
        exp_q.push_back(e);
    endtask

    task automatic ring(input int n, input logic h, input logic rs, input logic r);
        logic [4:0] one;
        one = 5'd1;
        for (int i = 0; i < n; i++) begin
            step(r, one << ph, h, rs);
            ph = (ph + 1) % 5;
        end
    endtask

    task automatic ring_to(input int target);
        for (int i = 0; i < 5 && ph != target; i++) ring(1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare each cycle's outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks += 4;
                if ({en_wb, en_mem, en_ex, en_id, en_if} !== e.en) begin
                    n_fail++;
                    $display("FAIL enables t=%0t got=%b exp=%b", $time,
                             {en_wb, en_mem, en_ex, en_id, en_if}, e.en);
                end
                if (halted !== e.hlt) begin
                    n_fail++;
                    $display("FAIL halted t=%0t got=%b exp=%b", $time, halted, e.hlt);
                end
                if (phase_err !== e.err) begin
                    n_fail++;
                    $display("FAIL phase_err t=%0t got=%b exp=%b", $time, phase_err, e.err);
                end
                if (retire_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL retire_cnt t=%0t got=%0d exp=%0d", $time, retire_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [4:0] pv;
        logic [4:0] one;
        one = 5'd1;
        ring(3, 1'b0, 1'b0, 1'b1);
        ring_to(0);
        ring(17, 1'b0, 1'b0, 1'b0);

        // Halt requested while en_ex is visible, then resume.
        ring_to(4);
        ring(1, 1'b1, 1'b0, 1'b0);
        ring(10, 1'b0, 1'b0, 1'b0);
        ring(1, 1'b0, 1'b1, 1'b0);
        ring(15, 1'b0, 1'b0, 1'b0);

        // Halt coinciding with sp5, halt ignored while halted, halt+resume together.
        ring_to(0);
        ring(1, 1'b1, 1'b0, 1'b0);
        ring(6, 1'b1, 1'b0, 1'b0);
        ring(1, 1'b1, 1'b1, 1'b0);
        ring(3, 1'b0, 1'b1, 1'b0);
        ring(90, 1'b0, 1'b0, 1'b0);

        // Reset while HALTING with en_id visible.
        ring_to(1);
        ring(1, 1'b1, 1'b0, 1'b0);
        ring(1, 1'b0, 1'b0, 1'b0);
        ring(1, 1'b0, 1'b0, 1'b1);
        ring(15, 1'b0, 1'b0, 1'b0);

        // Malformed sample: p2 and p4 together.
        ring_to(1);
        step(1'b0, 5'b01010, 1'b0, 1'b0);
        ph = (ph + 1) % 5;
        ring(20, 1'b0, 1'b0, 1'b0);
        ring(2, 1'b0, 1'b0, 1'b1);
        ring(15, 1'b0, 1'b0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            pv = one << ph;
            if ($urandom_range(0, 399) == 0) pv = 5'($urandom);
            step(($urandom_range(0, 299) == 0), pv,
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0));
            ph = (ph + 1) % 5;
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, which sets the width of the retired-instruction counter.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports p1, p2, p3, p4, p5, input, 1 bit each: the five-phase ring from the phase counter, nominally one-hot, each phase high for one cycle, order p1→p2→p3→p4→p5→p1.
REQ-005 The block SHALL have port halt_req, input, 1 bit: level request to stop issuing stage enables at the next instruction boundary.
REQ-006 The block SHALL have port resume_req, input, 1 bit: single-cycle pulse that restarts issue from HALTED.
REQ-007 The block SHALL have ports en_if, en_id, en_ex, en_mem, en_wb, output, 1 bit each: stage enables, at most one high per cycle.
REQ-008 The block SHALL have port halted, output, 1 bit: high while in state HALTED.
REQ-009 The block SHALL have port retire_cnt, output, CNT_W bits: number of completed writeback phases.
REQ-010 The block SHALL have port phase_err, output, 1 bit: sticky phase-ring violation flag.

Function
REQ-011 The block SHALL register the phase inputs on every clock edge; the sampled vector is sp[5:1].
REQ-012 The FSM SHALL have exactly four states: IDLE, RUN, HALTING, HALTED.
REQ-013 IDLE SHALL go to RUN on the edge where sp==p1-only, and all enables SHALL stay low while in IDLE (sync to instruction start).
REQ-014 In RUN and HALTING, en_if/id/ex/mem/wb SHALL be registered copies of sp1..sp5, giving a 2-cycle latency from pN at the input to the matching enable.
REQ-015 RUN SHALL go to HALTING when halt_req is high; the current instruction SHALL complete (remaining enables still issue).
REQ-016 RUN with halt_req high in the same cycle sp5 is high SHALL go directly to HALTED after that en_wb; the instruction counts as retired.
REQ-017 HALTING SHALL go to HALTED on the edge sp5 is sampled high; halt_req dropping while in HALTING SHALL NOT cancel the halt.
REQ-018 HALTED SHALL keep all enables low and halted=1; resume_req SHALL move it to IDLE (resync to next p1); halt_req is ignored in HALTED.
REQ-019 If halt_req and resume_req are high together in HALTED, the resume SHALL take effect.
REQ-020 resume_req outside HALTED SHALL be ignored.
REQ-021 retire_cnt SHALL increment by 1 on each issued en_wb and wrap from 2^CNT_W-1 to 0 with no flag.

Reset
REQ-022 With reset high at an edge: state=IDLE, sp=0, all enables=0, halted=0, retire_cnt=0, phase_err=0; reset overrides every other input, including mid-instruction and during HALTING.
REQ-023 After reset releases, the first enable SHALL be en_if, two cycles after the first p1 sampled.

Configuration
REQ-024 With macro PHASE_CHECK_EN defined, the block SHALL flag a violation when sp is not one-hot or is not the ring successor of the previous sp, ignoring the first sample after reset or after leaving HALTED.
REQ-025 With PHASE_CHECK_EN defined, a violation SHALL set phase_err (held until reset), force the FSM to IDLE, and suppress enables from that cycle on.
REQ-026 With PHASE_CHECK_EN undefined, phase_err SHALL be tied to 0, no checker logic SHALL exist, and malformed sp SHALL pass through as enables without any check.

Structure
REQ-027 Shared package phase_pkg SHALL hold: NUM_PHASES=5, the FSM state enum typedef, and the typedef of the 5-bit phase vector.
REQ-028 The violation logic SHALL be one sub-module, phase_checker (inputs: sp, previous sp, and a check-valid qualifier; output: violation), instantiated only under PHASE_CHECK_EN.

Verification
REQ-029 Reset, then a clean ring for 3 revolutions -> en_if..en_wb one-hot, each 2 cycles after its pN; retire_cnt=3.
REQ-030 halt_req held 1 cycle at en_ex -> en_mem and en_wb still issue, then halted=1 with no further enables; resume_req pulse -> next en_if 2 cycles after the following p1.
REQ-031 halt_req and resume_req asserted together while HALTED -> FSM returns to IDLE; halted=0 next cycle.
REQ-032 Preload CNT_W=4, run 16 instructions -> retire_cnt goes 15→0 on the 16th en_wb.
REQ-033 With PHASE_CHECK_EN, inject p2 and p4 high together -> phase_err=1, enables low, phase_err stays high until reset; the same stimulus without the macro -> phase_err stays 0.
REQ-034 Reset asserted during HALTING at en_id -> next cycle all outputs are at reset values and no en_wb is issued.
